core_step_controller: RTL and testbench

//  Downstream consumer of clock_divider output. Turns the slow divided clock into

---
 rtl/core_step_pkg.sv | 27 ++
 rtl/tick_sync_edge.sv | 28 ++
 rtl/core_step_controller.sv | 106 ++++++++++
 tb/tb_core_step_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_step_pkg.sv
// Shared encodings and default sizes for the core step controller.
package core_step_pkg;

    localparam int NUM_CORES_DEF   = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 32;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ARM  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // The reserved mode encoding behaves exactly like HALT.
    function automatic logic is_halt(input logic [1:0] m);
        return (m == MODE_HALT) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes the divided slow clock into the fast domain and emits a
// one-cycle tick on each synchronized rising edge.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational edge so the registered enable lands SYNC_STAGES+1 edges after sampling.
    assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/core_step_controller.sv
// Converts slow-clock ticks into one-cycle core enable pulses with
// run / single-step / halt control, a step budget and a per-core mask.
module core_step_controller
    import core_step_pkg::*;
#(
    parameter int NUM_CORES   = NUM_CORES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 inclk,
    input  logic                 rst_n,
    input  logic                 slow_clk,
    input  logic [1:0]           mode,
    input  logic                 step_req,
    input  logic                 clr_count,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [CNT_W-1:0]     step_limit,
    output logic [NUM_CORES-1:0] core_en,
    output logic [CNT_W-1:0]     step_count,
    output logic                 busy,
    output logic                 limit_hit
);

    logic                 tick;
    logic                 issue;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_CORES-1:0] core_en_q;
    logic                 busy_q, limit_hit_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick (
        .clk_i  (inclk),
        .rst_ni (rst_n),
        .async_i(slow_clk),
        .tick_o (tick)
    );

    always_comb begin
        issue   = tick && (((state_q == ST_RUN) && (mode == MODE_RUN)) ||
                           ((state_q == ST_ARM) && (mode == MODE_STEP)));
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (issue) begin
            count_d = sat_inc(count_q);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_RUN) begin
                    state_d = ST_RUN;
                end else if ((mode == MODE_STEP) && step_req) begin
                    state_d = ST_ARM;
                end
            end
            ST_RUN: begin
                if (mode != MODE_RUN) begin
                    state_d = ST_IDLE;
                end else if (tick && (step_limit != '0) && (count_d >= step_limit)) begin
                    // >= rather than == so a count already past the budget stops on the next tick.
                    state_d = ST_DONE;
                end
            end
            ST_ARM: begin
                if ((mode != MODE_STEP) || tick) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (is_halt(mode)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            core_en_q   <= '0;
            busy_q      <= 1'b0;
            limit_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            core_en_q   <= issue ? core_mask : '0;
            busy_q      <= (state_d != ST_IDLE);
            limit_hit_q <= (state_d == ST_DONE);
        end
    end

    assign core_en    = core_en_q;
    assign step_count = count_q;
    assign busy       = busy_q;
    assign limit_hit  = limit_hit_q;

endmodule

// File: tb/tb_core_step_controller.sv
// Directed bench for core_step_controller with a pulse scoreboard.
module tb_core_step_controller;

    localparam int NC   = 4;
    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic          inclk = 1'b0;
    logic          rst_n;
    logic          slow_clk;
    logic [1:0]    mode;
    logic          step_req;
    logic          clr_count;
    logic [NC-1:0] core_mask;
    logic [CW-1:0] step_limit;
    logic [NC-1:0] core_en;
    logic [CW-1:0] step_count;
    logic          busy;
    logic          limit_hit;

    typedef struct {
        int            cyc;
        logic [NC-1:0] en;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    core_step_controller #(
        .NUM_CORES  (NC),
        .SYNC_STAGES(SYNC),
        .CNT_W      (CW)
    ) dut (
        .inclk     (inclk),
        .rst_n     (rst_n),
        .slow_clk  (slow_clk),
        .mode      (mode),
        .step_req  (step_req),
        .clr_count (clr_count),
        .core_mask (core_mask),
        .step_limit(step_limit),
        .core_en   (core_en),
        .step_count(step_count),
        .busy      (busy),
        .limit_hit (limit_hit)
    );

    always #5 inclk = ~inclk;
    always @(posedge inclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_pulse(input int at_cyc, input int cnt);
        exp_t e;
        e.cyc = at_cyc;
        e.en  = core_mask;
        e.cnt = cnt[CW-1:0];
        sb.push_back(e);
    endfunction

    // Every nonzero core_en must match the oldest expected pulse.
    always @(negedge inclk) begin
        if (core_en !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {28'b0, core_en}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_en", {28'b0, core_en}, {28'b0, e.en});
                chk("pulse_count", {28'b0, step_count}, {28'b0, e.cnt});
            end
        end
    end

    task automatic slow_tick(input int half, input bit expect_pulse);
        @(posedge inclk);
        #1 slow_clk = 1'b1;
        if (expect_pulse) begin
            exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
            push_pulse(cyc + SYNC + 1, exp_cnt);
        end
        repeat (half) @(posedge inclk);
        #1 slow_clk = 1'b0;
        repeat (half - 1) @(posedge inclk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        slow_clk   = 1'b0;
        mode       = 2'b00;
        step_req   = 1'b0;
        clr_count  = 1'b0;
        core_mask  = 4'b1011;
        step_limit = '0;

        // Reset state
        wait_cyc(3);
        chk("rst_core_en", {28'b0, core_en}, 32'h0);
        chk("rst_count", {28'b0, step_count}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_limit_hit", {31'b0, limit_hit}, 32'h0);
        @(negedge inclk);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("idle_busy", {31'b0, busy}, 32'h0);

        // 1: free run, unlimited, period 20
        mode = 2'b01;
        for (int i = 0; i < 3; i++) slow_tick(10, 1'b1);
        chk("run_busy", {31'b0, busy}, 32'h1);
        chk("run_count", {28'b0, step_count}, 32'd3);
        mode = 2'b00;
        wait_cyc(2);
        chk("halt_busy", {31'b0, busy}, 32'h0);
        clr_count = 1'b1;
        wait_cyc(1);
        clr_count = 1'b0;
        exp_cnt = 0;
        chk("clr_count", {28'b0, step_count}, 32'h0);

        // 2: budget of 3 pulses
        step_limit = 4'd3;
        mode = 2'b01;
        for (int i = 0; i < 3; i++) slow_tick(6, 1'b1);
        slow_tick(6, 1'b0);
        chk("done_count", {28'b0, step_count}, 32'd3);
        chk("done_limit_hit", {31'b0, limit_hit}, 32'h1);
        chk("done_busy", {31'b0, busy}, 32'h1);
        mode = 2'b00;
        wait_cyc(2);
        chk("done_exit_limit_hit", {31'b0, limit_hit}, 32'h0);
        chk("done_exit_busy", {31'b0, busy}, 32'h0);
        chk("done_exit_count", {28'b0, step_count}, 32'd3);
        step_limit = '0;

        // 3: single step, extra requests ignored
        mode = 2'b10;
        step_req = 1'b1;
        wait_cyc(1);
        step_req = 1'b0;
        chk("arm_busy", {31'b0, busy}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            wait_cyc(1);
            step_req = 1'b1;
            wait_cyc(1);
            step_req = 1'b0;
        end
        slow_tick(6, 1'b1);
        chk("step_idle_busy", {31'b0, busy}, 32'h0);
        slow_tick(6, 1'b0);
        chk("step_count", {28'b0, step_count}, 32'd4);

        // 4: leave RUN in the cycle the tick arrives
        mode = 2'b01;
        wait_cyc(1);
        @(posedge inclk);
        #1 slow_clk = 1'b1;
        repeat (2) @(posedge inclk);
        #1 mode = 2'b00;
        wait_cyc(1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        wait_cyc(3);
        slow_clk = 1'b0;
        wait_cyc(4);
        chk("abort_count", {28'b0, step_count}, 32'd4);

        // 5: clear coincident with tick, masked tick, saturation
        mode = 2'b01;
        wait_cyc(1);
        @(posedge inclk);
        #1 slow_clk = 1'b1;
        exp_cnt = 0;
        push_pulse(cyc + SYNC + 1, 0);
        repeat (2) @(posedge inclk);
        #1 clr_count = 1'b1;
        wait_cyc(1);
        clr_count = 1'b0;
        wait_cyc(3);
        slow_clk = 1'b0;
        wait_cyc(4);
        chk("clr_tick_count", {28'b0, step_count}, 32'h0);
        core_mask = 4'b0000;
        slow_tick(5, 1'b0);
        exp_cnt = 1;
        chk("mask0_count", {28'b0, step_count}, 32'd1);
        core_mask = 4'b0110;
        for (int i = 0; i < 17; i++) slow_tick(4, 1'b1);
        chk("sat_count", {28'b0, step_count}, 32'hF);
        mode = 2'b00;
        wait_cyc(2);
        step_limit = 4'd2;
        mode = 2'b01;
        slow_tick(4, 1'b1);
        chk("over_limit_hit", {31'b0, limit_hit}, 32'h1);
        chk("over_limit_count", {28'b0, step_count}, 32'hF);
        mode = 2'b11;
        wait_cyc(2);
        chk("rsvd_exit_limit_hit", {31'b0, limit_hit}, 32'h0);
        step_limit = '0;

        // 6: asynchronous reset while core_en is high
        core_mask = 4'b1011;
        mode = 2'b01;
        wait_cyc(1);
        @(posedge inclk);
        #1 slow_clk = 1'b1;
        repeat (3) @(posedge inclk);
        #1 chk("pre_rst_core_en", {28'b0, core_en}, 32'hB);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_core_en", {28'b0, core_en}, 32'h0);
        chk("async_rst_count", {28'b0, step_count}, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        wait_cyc(2);
        @(negedge inclk);
        rst_n = 1'b1;
        exp_cnt = 1;
        push_pulse(cyc + SYNC + 1, 1);
        wait_cyc(10);
        chk("post_rst_count", {28'b0, step_count}, 32'd1);
        slow_clk = 1'b0;
        mode = 2'b00;
        wait_cyc(4);

        chk("sb_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
